// File: rtl/buf_bus_rr_arbiter.sv
// Round-robin arbiter for a shared registered buffer line: one owner at a time,
// bounded hold time, and a one-cycle turnaround gap between owners.
module buf_bus_rr_arbiter #(
    parameter int N        = 4,
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8,
    localparam int OW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] din,
    output logic [N-1:0]    grant,
    output logic [DW-1:0]   bus_out,
    output logic            bus_valid,
    output logic [OW-1:0]   owner
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   bus_q, bus_d;
    logic            valid_q, valid_d;

    logic [2*N-1:0]  req_rot_w;
    logic [N-1:0]    req_rot;
    logic            win_found;
    logic [OW-1:0]   win_idx;

    // Rotate requests so bit 0 is the requester at ptr; the first set bit wins.
    assign req_rot_w = {req, req} >> ptr_q;
    assign req_rot   = req_rot_w[N-1:0];

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_idx   = OW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = N'(1) << win_idx;
                    owner_d = win_idx;
                    hold_d  = HW'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            GRANT: begin
                // Moving ptr past the owner demotes a timed-out requester to lowest priority.
                if (!req[owner_q] || (hold_q == HW'(MAX_HOLD))) begin
                    state_d = GAP;
                    grant_d = '0;
                    ptr_d   = OW'((int'(owner_q) + 1) % N);
                end else begin
                    hold_d  = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Buffer stage follows the registered grant, so data lags grant by one cycle.
    always_comb begin
        valid_d = |grant_q;
        bus_d   = (|grant_q) ? din[owner_q*DW +: DW] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
        end
    end

    assign grant     = grant_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign owner     = owner_q;

endmodule
